// File: rtl/ghyston_mem_pkg.sv
// Shared types for the cpu_2432 data-memory bridge: FSM states, lane index,
// byte width and a lowest-set-lane helper.
package ghyston_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  // Lowest lane whose mask bit is set; lane 0 when the mask is empty.
  function automatic lane_t first_lane(input logic [3:0] mask);
    lane_t r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[3 - i]) r = lane_t'(3 - i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_bridge_2432_sram_byte_cycle.sv
// One SRAM byte access: holds strobes for WAIT_STATES+1 cycles after i_start
// and flags the final cycle on o_last.
module sram_byte_cycle #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_start,
  input  logic i_write,
  output logic o_last,
  output logic o_ce_b,
  output logic o_oe_b,
  output logic o_we_b,
  output logic o_doe
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic          busy_q;
  logic          wr_q;
  logic [CW-1:0] cnt_q;

  assign o_last = busy_q && (cnt_q == CW'(WAIT_STATES));
  assign o_ce_b = ~busy_q;
  assign o_oe_b = ~(busy_q & ~wr_q);
  assign o_we_b = ~(busy_q & wr_q);
  assign o_doe  = busy_q & wr_q;

  // A start arriving on the last cycle chains straight into the next lane.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      busy_q <= 1'b0;
      wr_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (i_start) begin
      busy_q <= 1'b1;
      wr_q   <= i_write;
      cnt_q  <= '0;
    end else if (o_last) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ram_bridge_2432.sv
// Serialises cpu_2432 32-bit data accesses onto an 8-bit async SRAM and stalls
// the CPU via o_cpu_clk_en. Optional read buffer: RAM_BRIDGE_READ_BUF_EN.
module ram_bridge_2432
  import ghyston_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 26
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  output logic              o_cpu_clk_en,
  input  logic [23:0]       i_daddr,
  input  logic [31:0]       i_dout,
  input  logic              i_ram_rd,
  input  logic [3:0]        i_ram_wr,
  output logic [31:0]       o_din,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [BYTE_W-1:0] o_sram_dout,
  output logic              o_sram_doe,
  input  logic [BYTE_W-1:0] i_sram_din,
  output logic              o_sram_ce_b,
  output logic              o_sram_oe_b,
  output logic              o_sram_we_b
);

  state_t      state_q, state_d;
  logic [23:0] daddr_q;
  logic [31:0] dout_q;
  logic [3:0]  pending_q, pending_d;

  logic        start, start_wr, byte_last;
  lane_t       start_lane, cur_lane;
  logic [3:0]  remaining;
  logic [23:0] src_addr;
  logic [31:0] src_data;
  logic        req_wr, req_rd, buf_hit;

  assign req_wr    = |i_ram_wr;
  assign req_rd    = i_ram_rd & ~req_wr;
  assign cur_lane  = first_lane(pending_q);
  assign remaining = pending_q & ~(4'b0001 << cur_lane);

  sram_byte_cycle #(.WAIT_STATES(WAIT_STATES)) u_byte (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .i_start (start),
    .i_write (start_wr),
    .o_last  (byte_last),
    .o_ce_b  (o_sram_ce_b),
    .o_oe_b  (o_sram_oe_b),
    .o_we_b  (o_sram_we_b),
    .o_doe   (o_sram_doe)
  );

  // pending_q holds the lanes still to visit, including the active one, so
  // reads (all lanes) and masked writes share one sequencer.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    start        = 1'b0;
    start_wr     = 1'b0;
    start_lane   = cur_lane;
    o_cpu_clk_en = 1'b0;
    src_addr     = daddr_q;
    src_data     = dout_q;
    case (state_q)
      ST_IDLE: begin
        o_cpu_clk_en = i_clk_en;
        src_addr     = i_daddr;
        src_data     = i_dout;
        if (req_wr) begin
          o_cpu_clk_en = 1'b0;
          start        = 1'b1;
          start_wr     = 1'b1;
          start_lane   = first_lane(i_ram_wr);
          pending_d    = i_ram_wr;
          state_d      = ST_WR;
        end else if (req_rd && !buf_hit) begin
          o_cpu_clk_en = 1'b0;
          start        = 1'b1;
          start_lane   = '0;
          pending_d    = 4'b1111;
          state_d      = ST_RD;
        end
      end
      ST_RD, ST_WR: begin
        if (byte_last) begin
          pending_d = remaining;
          if (remaining != '0) begin
            start      = 1'b1;
            start_wr   = (state_q == ST_WR);
            start_lane = first_lane(remaining);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_cpu_clk_en = i_clk_en;
        if (i_clk_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      daddr_q     <= '0;
      dout_q      <= '0;
      o_sram_addr <= '0;
      o_sram_dout <= '0;
      o_din       <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (state_q == ST_IDLE && start) begin
        daddr_q <= i_daddr;
        dout_q  <= i_dout;
      end
      if (start) begin
        o_sram_addr <= {src_addr[ADDR_W-3:0], start_lane};
        if (start_wr) o_sram_dout <= src_data[{start_lane, 3'b000} +: BYTE_W];
      end
      if (state_q == ST_RD && byte_last) begin
        o_din[{cur_lane, 3'b000} +: BYTE_W] <= i_sram_din;
      end
    end
  end

`ifdef RAM_BRIDGE_READ_BUF_EN
  logic        buf_valid_q;
  logic [23:0] buf_tag_q;

  assign buf_hit = buf_valid_q && (buf_tag_q == i_daddr);

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
    end else if (state_q == ST_RD && state_d == ST_DONE) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= daddr_q;
    end else if (state_q == ST_IDLE && req_wr && i_daddr == buf_tag_q) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bridge_2432.sv
// Scoreboard bench for ram_bridge_2432: expected SRAM byte cycles and CPU
// completions are queued by the stimulus and popped by an independent monitor.
module tb_ram_bridge_2432;

  localparam int unsigned W    = 1;
  localparam int unsigned RDST = 4 * (W + 1) + 1;

  typedef struct {
    logic [25:0] addr;
    bit          wr;
    logic [7:0]  data;
    int unsigned len;
  } cyc_t;

  typedef struct {
    int unsigned stall;
    logic [31:0] din;
  } acc_t;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        clk_en = 1'b1;
  logic        cpu_en;
  logic [23:0] daddr = '0;
  logic [31:0] dout = '0;
  logic        rd = 1'b0;
  logic [3:0]  wr = '0;
  logic [31:0] din;
  logic [25:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_doe, ce_b, oe_b, we_b;

  logic [7:0]  mem [256];
  cyc_t        exp_cyc[$];
  acc_t        exp_acc[$];
  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  bit          in_seg = 1'b0;
  logic [25:0] s_addr;
  bit          s_wr, s_bad;
  logic [7:0]  s_data;
  int unsigned s_len;
  int unsigned stall = 0;

  ram_bridge_2432 #(.WAIT_STATES(W), .ADDR_W(26)) dut (
    .i_clk        (clk),
    .i_rstb       (rstb),
    .i_clk_en     (clk_en),
    .o_cpu_clk_en (cpu_en),
    .i_daddr      (daddr),
    .i_dout       (dout),
    .i_ram_rd     (rd),
    .i_ram_wr     (wr),
    .o_din        (din),
    .o_sram_addr  (sram_addr),
    .o_sram_dout  (sram_dout),
    .o_sram_doe   (sram_doe),
    .i_sram_din   (sram_din),
    .o_sram_ce_b  (ce_b),
    .o_sram_oe_b  (oe_b),
    .o_sram_we_b  (we_b)
  );

  always #5 clk = ~clk;

  assign sram_din = (!ce_b && !oe_b) ? mem[sram_addr[7:0]] : 8'hEE;

  always @(negedge clk) begin
    if (!ce_b && !we_b && sram_doe) mem[sram_addr[7:0]] = sram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic close_seg();
    cyc_t e;
    if (exp_cyc.size() == 0) begin
      ncmp++;
      nerr++;
      $display("FAIL seg_extra: got cycle at %h expected none", s_addr);
    end else begin
      e = exp_cyc.pop_front();
      check("seg_addr", 32'(s_addr), 32'(e.addr));
      check("seg_kind", 32'(s_wr), 32'(e.wr));
      if (e.wr) check("seg_data", 32'(s_data), 32'(e.data));
      check("seg_len", s_len, e.len);
      check("seg_strobes", 32'(s_bad), 32'd0);
    end
  endtask

  // Monitor: segments SRAM byte cycles by address and times CPU completions.
  always @(negedge clk) begin
    bit ok;
    ok = (!we_b) ? (oe_b && sram_doe) : (!oe_b && !sram_doe);
    if (!ce_b) begin
      if (in_seg && sram_addr == s_addr) begin
        s_len++;
        if (!ok || (s_wr && sram_dout !== s_data)) s_bad = 1'b1;
      end else begin
        if (in_seg) close_seg();
        in_seg = 1'b1;
        s_addr = sram_addr;
        s_wr   = !we_b;
        s_data = sram_dout;
        s_len  = 1;
        s_bad  = !ok;
      end
    end else if (in_seg) begin
      close_seg();
      in_seg = 1'b0;
    end

    if (!rstb) begin
      stall = 0;
    end else if (rd || (wr != '0)) begin
      if (cpu_en && clk_en) begin
        acc_t a;
        if (exp_acc.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL acc_extra: got completion expected none");
        end else begin
          a = exp_acc.pop_front();
          check("stall", stall, a.stall);
          check("din", din, a.din);
        end
        stall = 0;
      end else if (!cpu_en) begin
        stall++;
      end
    end
  end

  task automatic push_rd(input logic [23:0] a);
    for (int unsigned l = 0; l < 4; l++)
      exp_cyc.push_back('{addr: {a, 2'(l)}, wr: 1'b0, data: 8'h00, len: W + 1});
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [3:0] m, input logic [31:0] d);
    for (int unsigned l = 0; l < 4; l++)
      if (m[l]) exp_cyc.push_back('{addr: {a, 2'(l)}, wr: 1'b1, data: d[8*l +: 8], len: W + 1});
  endtask

  // CPU model: holds the request until an enabled, un-stalled cycle.
  task automatic do_acc(input logic [23:0] a, input logic r, input logic [3:0] m,
                        input logic [31:0] d, input bit sram, input int unsigned st,
                        input logic [31:0] din_exp, input bit dlow);
    int unsigned cyc;
    bit done;
    if (m != '0) push_wr(a, m, d);
    else if (sram) push_rd(a);
    exp_acc.push_back('{stall: st, din: din_exp});
    daddr = a; rd = r; wr = m; dout = d;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (cpu_en && clk_en) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (dlow && cyc == RDST) clk_en = 1'b0;
      if (dlow && cyc == RDST + 3) clk_en = 1'b1;
    end
    if (!done) begin
      ncmp++;
      nerr++;
      $display("FAIL timeout: got no completion for addr %h expected one", a);
    end
    rd = 1'b0; wr = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    mem[8'h52] = 8'h5A; mem[8'h53] = 8'h5B;

    repeat (3) @(posedge clk);
    #1;
    check("rst_din", din, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dout", 32'(sram_dout), 32'h0);
    check("rst_strobes", {28'h0, ce_b, oe_b, we_b, sram_doe}, 32'hE);
    check("rst_cpu_en", 32'(cpu_en), 32'h1);
    rstb = 1'b1;
    @(posedge clk); #1;

    do_acc(24'h000010, 1'b1, 4'b0000, 32'h0, 1'b1, RDST, 32'h44332211, 1'b0);
    do_acc(24'h000020, 1'b0, 4'b0100, 32'h00AB0000, 1'b1, W + 2, 32'h44332211, 1'b0);
    check("mem_82", 32'(mem[8'h82]), 32'hAB);
`ifdef RAM_BRIDGE_READ_BUF_EN
    do_acc(24'h000010, 1'b1, 4'b0000, 32'h0, 1'b0, 0, 32'h44332211, 1'b0);
`else
    do_acc(24'h000010, 1'b1, 4'b0000, 32'h0, 1'b1, RDST, 32'h44332211, 1'b0);
`endif
    do_acc(24'h000010, 1'b0, 4'b0001, 32'h00000099, 1'b1, W + 2, 32'h44332211, 1'b0);
    do_acc(24'h000010, 1'b1, 4'b0000, 32'h0, 1'b1, RDST, 32'h44332299, 1'b0);
    do_acc(24'h000012, 1'b0, 4'b1111, 32'hDDCCBBAA, 1'b1, RDST, 32'h44332299, 1'b0);
    do_acc(24'h000012, 1'b1, 4'b0000, 32'h0, 1'b1, RDST + 3, 32'hDDCCBBAA, 1'b1);
    do_acc(24'h000013, 1'b1, 4'b0010, 32'h0000EE00, 1'b1, W + 2, 32'hDDCCBBAA, 1'b0);

    // Reset during the last cycle of lane 1 of a four-lane write.
    push_wr(24'h000014, 4'b0011, 32'h87654321);
    daddr = 24'h000014; rd = 1'b0; wr = 4'b1111; dout = 32'h87654321;
    repeat (2 * (W + 1)) @(posedge clk);
    #1;
    rstb = 1'b0; wr = '0;
    @(posedge clk); #1;
    check("midrst_strobes", {28'h0, ce_b, oe_b, we_b, sram_doe}, 32'hE);
    check("midrst_din", din, 32'h0);
    check("midrst_cpu_en", 32'(cpu_en), 32'h1);
    rstb = 1'b1;
    do_acc(24'h000014, 1'b1, 4'b0000, 32'h0, 1'b1, RDST, 32'h5B5A4321, 1'b0);
    check("mem_52", 32'(mem[8'h52]), 32'h5A);

    repeat (3) @(posedge clk);
    #1;
    check("cyc_q_left", exp_cyc.size(), 0);
    check("acc_q_left", exp_acc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected one");
    $fatal(1, "watchdog");
  end

endmodule
